loop_fetch_sequencer: RTL

- IF-stage PC/instruction sequencer directly upstream of the stream loop detector.
- Normally fetches from IMEM and loads the IF/ID register, whose PC and instruction outputs feed the detector.
- While the detector holds its block signal, stops IMEM fetch and replays loop-buffer instructions with the matching replay PC.
- Recovers to the corrected PC on mispredict or detector flush.

---
 rtl/loop_fetch_sequencer.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/loop_fetch_sequencer.sv
// IF-stage PC / instruction sequencer sitting upstream of the stream loop
// detector. It fetches from IMEM into the IF/ID register. While the detector
// holds its block signal, it replays loop-buffer instructions at the matching
// PCs. It recovers to a corrected PC on a mispredict or a detector flush.
module loop_fetch_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          LOOP_DEPTH = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        ex_redirect,
  input  logic [31:0] ex_target,
  input  logic        mispredict,
  input  logic [31:0] correct_pc,
  input  logic        loop_block,
  input  logic [31:0] loop_new_pc,
  input  logic [31:0] loop_target_pc,
  input  logic        loop_flush,
  input  logic [31:0] loop_instruction,
  input  logic [31:0] imem_instruction,
  output logic [31:0] imem_addr,
  output logic        imem_en,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instruction,
  output logic        if_id_valid,
  output logic        if_id_from_loop,
  output logic [15:0] replay_count
);

  localparam logic [31:0] L_DEPTH = 32'(LOOP_DEPTH);

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_REPLAY  = 2'd1,
    ST_RECOVER = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_replay_pc;
  logic [31:0] r_br_pc;
  logic [31:0] r_start_pc;
  logic [31:0] r_exit_pc;
  logic        r_imem_en;
  logic [31:0] r_if_id_pc;
  logic [31:0] r_if_id_instruction;
  logic        r_if_id_valid;
  logic        r_if_id_from_loop;
  logic [15:0] r_replay_count;

  logic [31:0] w_br_pc;
  logic [31:0] w_span_words;
  logic        w_refuse;
  logic        w_enter;
  logic        w_recover;
  logic [31:0] w_fetch_next_pc;
  logic        w_replay_wrap;
  logic [31:0] w_replay_next_pc;
  logic [15:0] w_count_inc;

  // The loop branch sits one word below the detector's fall-through PC.
  // A loop body that starts after its branch, or that holds more words than
  // the buffer, is refused and fetched normally from IMEM.
  assign w_br_pc      = loop_new_pc - 32'd4;
  assign w_span_words = (w_br_pc - loop_target_pc) >> 2;
  assign w_refuse     = (loop_target_pc > w_br_pc) || (w_span_words >= L_DEPTH);
  assign w_enter      = loop_block && !w_refuse;
  assign w_recover    = mispredict || loop_flush;

  assign w_fetch_next_pc  = ex_redirect ? ex_target : (r_pc + 32'd4);
  assign w_replay_wrap    = (r_replay_pc == r_br_pc);
  assign w_replay_next_pc = w_replay_wrap ? r_start_pc : (r_replay_pc + 32'd4);
  assign w_count_inc      = (r_replay_count == 16'hFFFF) ? r_replay_count
                                                         : (r_replay_count + 16'd1);

  // Sequencer FSM: reset, then recovery, then stall, then the per-state update.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state             <= ST_FETCH;
      r_pc                <= RESET_PC;
      r_replay_pc         <= 32'd0;
      r_br_pc             <= 32'd0;
      r_start_pc          <= 32'd0;
      r_exit_pc           <= 32'd0;
      r_imem_en           <= 1'b1;
      r_if_id_pc          <= 32'd0;
      r_if_id_instruction <= 32'd0;
      r_if_id_valid       <= 1'b0;
      r_if_id_from_loop   <= 1'b0;
      r_replay_count      <= 16'd0;
    end else if (w_recover) begin
      // Recovery redirects even while ID is stalled.
      r_state           <= ST_RECOVER;
      r_pc              <= correct_pc;
      r_imem_en         <= 1'b1;
      r_if_id_valid     <= 1'b0;
      r_if_id_from_loop <= 1'b0;
    end else if (stall) begin
      r_state <= r_state;
    end else begin
      case (r_state)
        ST_FETCH, ST_RECOVER: begin
          if (w_enter) begin
            // Enter replay. This cycle's IMEM fetch is dropped, leaving a bubble.
            r_state        <= ST_REPLAY;
            r_br_pc        <= w_br_pc;
            r_start_pc     <= loop_target_pc;
            r_exit_pc      <= loop_new_pc;
            r_replay_pc    <= loop_target_pc;
            r_replay_count <= 16'd0;
            r_imem_en      <= 1'b0;
            r_if_id_valid  <= 1'b0;
          end else begin
            r_state             <= ST_FETCH;
            r_pc                <= w_fetch_next_pc;
            r_imem_en           <= 1'b1;
            r_if_id_pc          <= r_pc;
            r_if_id_instruction <= imem_instruction;
            r_if_id_valid       <= 1'b1;
            r_if_id_from_loop   <= 1'b0;
          end
        end
        ST_REPLAY: begin
          if (!loop_block) begin
            // The detector released the loop. Resume fetching after the branch.
            r_state           <= ST_FETCH;
            r_pc              <= r_exit_pc;
            r_imem_en         <= 1'b1;
            r_if_id_valid     <= 1'b0;
            r_if_id_from_loop <= 1'b0;
          end else begin
            r_if_id_pc          <= r_replay_pc;
            r_if_id_instruction <= loop_instruction;
            r_if_id_valid       <= 1'b1;
            r_if_id_from_loop   <= 1'b1;
            r_replay_pc         <= w_replay_next_pc;
            if (w_replay_wrap) begin
              r_replay_count <= w_count_inc;
            end else begin
              r_replay_count <= r_replay_count;
            end
          end
        end
        default: begin
          r_state       <= ST_FETCH;
          r_imem_en     <= 1'b1;
          r_if_id_valid <= 1'b0;
        end
      endcase
    end
  end

  assign imem_addr         = r_pc;
  assign imem_en           = r_imem_en;
  assign if_id_pc          = r_if_id_pc;
  assign if_id_instruction = r_if_id_instruction;
  assign if_id_valid       = r_if_id_valid;
  assign if_id_from_loop   = r_if_id_from_loop;
  assign replay_count      = r_replay_count;

endmodule
